// File: rtl/ex_pkg.sv
// Shared types for the execute-stage multi-cycle unit sequencer.
package ex_pkg;

  typedef enum logic [1:0] {
    U_NONE,
    U_MUL,
    U_DIV,
    U_FPU
  } unit_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } mc_state_e;

  localparam int MC_MAX_LAT_DEF = 64;

endpackage

// File: rtl/ex_lat_watchdog.sv
// Latency watchdog: counts enabled cycles, saturating at MAX_LAT.
module ex_lat_watchdog #(
  parameter int MAX_LAT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != CNT_W'(MAX_LAT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires in the MAX_LAT-th enabled cycle since the last clear.
  assign expired = en && (cnt_q >= CNT_W'(MAX_LAT - 1));

endmodule

// File: rtl/ex_multicycle_ctrl.sv
// Launches mul/div/fpu, stalls EX until ready, and presents the
// captured result for one advancing cycle.
module ex_multicycle_ctrl
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MAX_LAT = MC_MAX_LAT_DEF,
  parameter int CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            issue_valid,
  input  unit_e           issue_unit,
  input  logic [4:0]      issue_rd,
  input  logic            hold,
  input  logic            flush,
  output logic            mul_start,
  output logic            div_start,
  output logic            fpu_start,
  input  logic            mul_ready,
  input  logic            div_ready,
  input  logic            fpu_ready,
  input  logic [XLEN-1:0] mul_res,
  input  logic [XLEN-1:0] div_res,
  input  logic [XLEN-1:0] fpu_res,
  output logic            ex_stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res,
  output logic [4:0]      res_rd,
  output logic            timeout
);

  mc_state_e       state_q, state_d;
  unit_e           unit_q, unit_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      res_rd_q, res_rd_d;
  logic            timeout_q, timeout_d;

  unit_e           start_sel;
  logic            stall;
  logic            sel_ready;
  logic [XLEN-1:0] sel_res;
  logic            issue_ok;
  logic            wd_clr;
  logic            wd_en;
  logic            expired;

  ex_lat_watchdog #(
    .MAX_LAT (MAX_LAT),
    .CNT_W   (CNT_W)
  ) u_wd (
    .clk     (clk),
    .rst     (Rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (expired)
  );

  always_comb begin
    sel_ready = 1'b0;
    sel_res   = '0;
    unique case (unit_q)
      U_MUL: begin
        sel_ready = mul_ready;
        sel_res   = mul_res;
      end
      U_DIV: begin
        sel_ready = div_ready;
        sel_res   = div_res;
      end
      U_FPU: begin
        sel_ready = fpu_ready;
        sel_res   = fpu_res;
      end
      default: ;
    endcase
  end

  assign issue_ok = issue_valid && (issue_unit != U_NONE);
  assign wd_en    = (state_q == BUSY) || (state_q == DRAIN);
  assign wd_clr   = (state_d != state_q);

  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    rd_d      = rd_q;
    res_d     = res_q;
    res_rd_d  = res_rd_q;
    timeout_d = timeout_q;
    start_sel = U_NONE;
    stall     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue_ok && !hold && !flush) begin
          start_sel = issue_unit;
          stall     = 1'b1;
          unit_d    = issue_unit;
          rd_d      = issue_rd;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_d = DRAIN;
        end else if (sel_ready) begin
          res_d    = sel_res;
          res_rd_d = rd_q;
          state_d  = DONE;
        end else if (expired) begin
          res_d     = '1;
          res_rd_d  = rd_q;
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // The completed op is still in ID/EX, so issue is ignored here.
        if (flush || !hold)
          state_d = IDLE;
      end
      DRAIN: begin
        stall = issue_ok;
        if (sel_ready) begin
          state_d = IDLE;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      unit_q    <= U_NONE;
      rd_q      <= '0;
      res_q     <= '0;
      res_rd_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      res_rd_q  <= res_rd_d;
      timeout_q <= timeout_d;
    end
  end

  assign mul_start = !Rst && (start_sel == U_MUL);
  assign div_start = !Rst && (start_sel == U_DIV);
  assign fpu_start = !Rst && (start_sel == U_FPU);
  assign ex_stall  = !Rst && stall;
  assign res_valid = (state_q == DONE);
  assign res       = res_q;
  assign res_rd    = res_rd_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
// Directed bench for ex_multicycle_ctrl with immediate assertions.
module tb_ex_multicycle_ctrl;
  import ex_pkg::*;

  logic        clk;
  logic        Rst;
  logic        issue_valid;
  unit_e       issue_unit;
  logic [4:0]  issue_rd;
  logic        hold;
  logic        flush;
  logic        mul_start, div_start, fpu_start;
  logic        mul_ready, div_ready, fpu_ready;
  logic [31:0] mul_res, div_res, fpu_res;
  logic        ex_stall;
  logic        res_valid;
  logic [31:0] res;
  logic [4:0]  res_rd;
  logic        timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int n_mul  = 0;
  int n_div  = 0;
  int base;

  ex_multicycle_ctrl dut (
    .clk         (clk),
    .Rst         (Rst),
    .issue_valid (issue_valid),
    .issue_unit  (issue_unit),
    .issue_rd    (issue_rd),
    .hold        (hold),
    .flush       (flush),
    .mul_start   (mul_start),
    .div_start   (div_start),
    .fpu_start   (fpu_start),
    .mul_ready   (mul_ready),
    .div_ready   (div_ready),
    .fpu_ready   (fpu_ready),
    .mul_res     (mul_res),
    .div_res     (div_res),
    .fpu_res     (fpu_res),
    .ex_stall    (ex_stall),
    .res_valid   (res_valid),
    .res         (res),
    .res_rd      (res_rd),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_start === 1'b1) n_mul++;
    if (div_start === 1'b1) n_div++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1;
    issue_valid = 1'b0;
    issue_unit = U_NONE;
    issue_rd = '0;
    hold = 1'b0;
    flush = 1'b0;
    mul_ready = 1'b0;
    div_ready = 1'b0;
    fpu_ready = 1'b0;
    mul_res = '0;
    div_res = '0;
    fpu_res = '0;
    #2;
    chk("rst_stall", ex_stall, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_mstart", mul_start, 0);
    #10 Rst = 1'b0;

    // MUL, ready 3 cycles after start
    tick();
    issue_valid = 1'b1;
    issue_unit = U_MUL;
    issue_rd = 5'd5;
    #1;
    chk("t1_start", mul_start, 1);
    chk("t1_dstart", div_start, 0);
    chk("t1_stall_l", ex_stall, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) begin
        mul_ready = 1'b1;
        mul_res = 32'h0000_0C35;
      end
      #1;
      chk("t1_stall_b", ex_stall, 1);
      chk("t1_nostart", mul_start, 0);
      chk("t1_novalid", res_valid, 0);
    end
    tick();
    mul_ready = 1'b0;
    mul_res = 32'hDEAD_BEEF;
    #1;
    chk("t1_valid", res_valid, 1);
    chk("t1_res", res, 32'h0000_0C35);
    chk("t1_rd", res_rd, 5);
    chk("t1_stall_done", ex_stall, 0);
    chk("t1_noreissue", mul_start, 0);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("t1_valid_off", res_valid, 0);
    chk("t1_res_hold", res, 32'h0000_0C35);

    // DIV, ready after 33 cycles, hold during DONE
    base = n_div;
    tick();
    issue_valid = 1'b1;
    issue_unit = U_DIV;
    issue_rd = 5'd7;
    #1;
    chk("t2_start", div_start, 1);
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 33) begin
        div_ready = 1'b1;
        div_res = 32'h1234_5678;
      end
      #1;
      chk("t2_stall", ex_stall, 1);
    end
    tick();
    div_ready = 1'b0;
    div_res = 32'h0;
    hold = 1'b1;
    #1;
    chk("t2_valid1", res_valid, 1);
    chk("t2_res1", res, 32'h1234_5678);
    chk("t2_nostall", ex_stall, 0);
    tick();
    #1;
    chk("t2_valid2", res_valid, 1);
    chk("t2_res2", res, 32'h1234_5678);
    tick();
    hold = 1'b0;
    #1;
    chk("t2_valid3", res_valid, 1);
    chk("t2_res3", res, 32'h1234_5678);
    chk("t2_rd", res_rd, 7);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("t2_valid_off", res_valid, 0);
    chk("t2_one_start", n_div - base, 1);

    // Flush DIV in BUSY cycle 2, MUL waits in DRAIN
    base = n_mul;
    tick();
    issue_valid = 1'b1;
    issue_unit = U_DIV;
    issue_rd = 5'd9;
    #1;
    tick();
    #1;
    tick();
    flush = 1'b1;
    #1;
    chk("t3_stall_b2", ex_stall, 1);
    tick();
    flush = 1'b0;
    issue_unit = U_MUL;
    issue_rd = 5'd10;
    #1;
    chk("t3_drain_stall", ex_stall, 1);
    chk("t3_drain_nostart", mul_start, 0);
    chk("t3_drain_novalid", res_valid, 0);
    tick();
    #1;
    chk("t3_drain_stall2", ex_stall, 1);
    tick();
    div_ready = 1'b1;
    div_res = 32'hBAD0_BAD0;
    #1;
    chk("t3_drain_nostart2", mul_start, 0);
    tick();
    div_ready = 1'b0;
    #1;
    chk("t3_mstart", mul_start, 1);
    chk("t3_novalid", res_valid, 0);
    chk("t3_res_kept", res, 32'h1234_5678);
    tick();
    #1;
    tick();
    mul_ready = 1'b1;
    mul_res = 32'h0000_0011;
    #1;
    tick();
    mul_ready = 1'b0;
    #1;
    chk("t3_valid", res_valid, 1);
    chk("t3_res", res, 32'h0000_0011);
    chk("t3_rd", res_rd, 10);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("t3_one_mstart", n_mul - base, 1);

    // Back-to-back MUL with issue_valid held high in DONE
    base = n_mul;
    tick();
    issue_valid = 1'b1;
    issue_unit = U_MUL;
    issue_rd = 5'd3;
    #1;
    tick();
    mul_ready = 1'b1;
    mul_res = 32'h0000_000A;
    #1;
    tick();
    mul_ready = 1'b0;
    #1;
    chk("t4_valid_a", res_valid, 1);
    chk("t4_res_a", res, 32'h0000_000A);
    chk("t4_done_nostart", mul_start, 0);
    tick();
    issue_rd = 5'd4;
    #1;
    chk("t4_start_b", mul_start, 1);
    chk("t4_valid_off", res_valid, 0);
    tick();
    mul_ready = 1'b1;
    mul_res = 32'h0000_000B;
    #1;
    tick();
    mul_ready = 1'b0;
    #1;
    chk("t4_res_b", res, 32'h0000_000B);
    chk("t4_rd_b", res_rd, 4);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("t4_two_starts", n_mul - base, 2);

    // FPU never ready; other units' ready is ignored
    tick();
    issue_valid = 1'b1;
    issue_unit = U_FPU;
    issue_rd = 5'd12;
    #1;
    chk("t5_start", fpu_start, 1);
    for (int i = 1; i <= 64; i++) begin
      tick();
      mul_ready = 1'b1;
      div_ready = 1'b1;
      #1;
      chk("t5_stall", ex_stall, 1);
      chk("t5_novalid", res_valid, 0);
    end
    tick();
    mul_ready = 1'b0;
    div_ready = 1'b0;
    #1;
    chk("t5_valid", res_valid, 1);
    chk("t5_res", res, 32'hFFFF_FFFF);
    chk("t5_rd", res_rd, 12);
    chk("t5_timeout", timeout, 1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("t5_sticky", timeout, 1);
    chk("t5_valid_off", res_valid, 0);

    // Async reset mid-BUSY
    tick();
    issue_valid = 1'b1;
    issue_unit = U_MUL;
    issue_rd = 5'd1;
    #1;
    tick();
    #1;
    chk("t6_busy", ex_stall, 1);
    #2 Rst = 1'b1;
    #1;
    chk("t6_stall", ex_stall, 0);
    chk("t6_mstart", mul_start, 0);
    chk("t6_valid", res_valid, 0);
    chk("t6_res", res, 0);
    chk("t6_rd", res_rd, 0);
    chk("t6_timeout", timeout, 0);
    issue_valid = 1'b0;
    #2 Rst = 1'b0;
    tick();
    mul_ready = 1'b1;
    mul_res = 32'h5555_AAAA;
    #1;
    tick();
    mul_ready = 1'b0;
    #1;
    chk("t6_stray_valid", res_valid, 0);
    chk("t6_stray_res", res, 0);
    chk("t6_stray_stall", ex_stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
